// File: rtl/icache.sv
// ============================================================================
// Module   : icache
// Purpose  : Direct-mapped, one-word-per-line instruction cache with
//            single-outstanding miss handling. Optional hit/miss statistics
//            are enabled by defining ICACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    input  logic        clear_in,
    output logic        if_ready,
    output logic [31:0] if_inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MISS = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             discard_q, discard_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_BITS-1:0] w_fill_idx;
    logic [TAG_W-1:0]      w_fill_tag;
    logic                  w_hit;
    logic                  w_fill;
    logic                  w_fill_en;
    logic                  unused_pc_lsb;

    assign w_idx         = if_pc[INDEX_BITS+1:2];
    assign w_tag         = if_pc[31:INDEX_BITS+2];
    assign w_fill_idx    = mem_addr_q[INDEX_BITS+1:2];
    assign w_fill_tag    = mem_addr_q[31:INDEX_BITS+2];
    assign unused_pc_lsb = ^if_pc[1:0];

    assign w_hit    = if_req & valid_q[w_idx] & (tag_q[w_idx] == w_tag);
    assign if_ready = (state_q == S_IDLE) & w_hit;
    assign if_inst  = valid_q[w_idx] ? data_q[w_idx] : 32'd0;
    assign mem_req  = (state_q == S_MISS);
    assign mem_addr = mem_addr_q;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        mem_addr_d = mem_addr_q;
        discard_d  = discard_q;
        w_fill     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_req && !w_hit && !clear_in) begin
                    state_d    = S_MISS;
                    mem_addr_d = {if_pc[31:2], 2'b00};
                end
            end
            S_MISS: begin
                if (mem_done) begin
                    // A flush seen during or at the end of the miss drops the word.
                    w_fill    = !discard_q && !clear_in;
                    state_d   = S_IDLE;
                    discard_d = 1'b0;
                end else if (clear_in) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (w_fill) begin
            valid_d[w_fill_idx] = 1'b1;
        end
        if (clear_in) begin
            valid_d = '0;
        end
    end

    assign w_fill_en = w_fill & rdy_in & rst_in;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            mem_addr_q <= 32'd0;
            discard_q  <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            mem_addr_q <= mem_addr_d;
            discard_q  <= discard_d;
        end
    end

    // Tag/data arrays need no reset: valid bits gate every read.
    always_ff @(posedge clk_in) begin
        if (w_fill_en) begin
            tag_q[w_fill_idx]  <= w_fill_tag;
            data_q[w_fill_idx] <= mem_data;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (rdy_in) begin
            if (if_ready && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == S_IDLE) && (state_d == S_MISS) && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    // Statistics disabled: no counters or counter ports.
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
// Module   : tb_icache
// Purpose  : Directed scenarios plus randomized traffic for icache, checked
//            against a line-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache;

    localparam int IB = 4;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic        clear_in = 1'b0;
    logic        if_ready;
    logic [31:0] if_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done = 1'b0;
    logic [31:0] mem_data = 32'd0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache #(.INDEX_BITS(IB)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .if_req   (if_req),
        .if_pc    (if_pc),
        .clear_in (clear_in),
        .if_ready (if_ready),
        .if_inst  (if_inst),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_done (mem_done),
        .mem_data (mem_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Model: each line remembers the full word address it holds.
    typedef struct {
        bit          v;
        logic [29:0] wa;
        logic [31:0] d;
    } line_t;

    line_t       lines [16];
    bit          m_miss;
    bit          m_disc;
    logic [31:0] m_addr;
    logic [31:0] m_hit;
    logic [31:0] m_mis;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1004) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic bit model_hit(input bit req, input logic [31:0] pc);
        return !m_miss && req && lines[pc[5:2]].v && (lines[pc[5:2]].wa == pc[31:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) lines[i].v = 1'b0;
        m_miss = 1'b0;
        m_disc = 1'b0;
        m_addr = 32'd0;
        m_hit  = 32'd0;
        m_mis  = 32'd0;
    endtask

    // One cycle: drive after the falling edge, check, then advance the model.
    task automatic step(input bit rst, input bit rdy, input bit req, input logic [31:0] pc,
                        input bit clr, input bit done);
        bit hit;
        rst_in   = rst;
        rdy_in   = rdy;
        if_req   = req;
        if_pc    = pc;
        clear_in = clr;
        mem_done = done;
        mem_data = done ? mem_word(m_addr) : $urandom;
        #1;
        hit = model_hit(req, pc);
        check_eq("if_ready", {31'd0, if_ready}, {31'd0, hit});
        if (hit) check_eq("if_inst", if_inst, lines[pc[5:2]].d);
        else if (!m_miss && !lines[pc[5:2]].v) check_eq("if_inst_invalid", if_inst, 32'd0);
        check_eq("mem_req", {31'd0, mem_req}, {31'd0, m_miss});
        check_eq("mem_addr", mem_addr, m_addr);
`ifdef ICACHE_STATS_EN
        check_eq("hit_cnt", hit_cnt, m_hit);
        check_eq("miss_cnt", miss_cnt, m_mis);
`endif
        @(posedge clk_in);
        if (!rst) begin
            model_reset();
        end else if (rdy) begin
            if (!m_miss) begin
                if (hit && m_hit != 32'hFFFF_FFFF) m_hit++;
                if (req && !hit && !clr) begin
                    m_miss = 1'b1;
                    m_addr = {pc[31:2], 2'b00};
                    if (m_mis != 32'hFFFF_FFFF) m_mis++;
                end
            end else if (done) begin
                if (!m_disc && !clr) begin
                    lines[m_addr[5:2]].v  = 1'b1;
                    lines[m_addr[5:2]].wa = m_addr[31:2];
                    lines[m_addr[5:2]].d  = mem_word(m_addr);
                end
                m_miss = 1'b0;
                m_disc = 1'b0;
            end else if (clr) begin
                m_disc = 1'b1;
            end
            if (clr) for (int i = 0; i < 16; i++) lines[i].v = 1'b0;
        end
        @(negedge clk_in);
    endtask

    // Miss on pc, wait lat cycles, then complete; pc stays on the bus.
    task automatic fill(input logic [31:0] pc, input int lat);
        step(1, 1, 1, pc, 0, 0);
        repeat (lat) step(1, 1, 1, pc, 0, 0);
        step(1, 1, 1, pc, 0, 1);
    endtask

    initial begin
        bit          rst, rdy, req, clr, done, was;
        logic [31:0] pc;
        int          lat;

        model_reset();
        @(negedge clk_in);
        step(0, 1, 0, 32'd0, 0, 0);
        step(0, 1, 1, 32'h1004, 0, 0);

        // Cold miss: mem_req high for exactly three cycles, then four hits.
        fill(32'h0000_1004, 2);
        repeat (4) step(1, 1, 1, 32'h0000_1004, 0, 0);
        step(1, 1, 0, 32'h0000_1004, 0, 0);
`ifdef ICACHE_STATS_EN
        check_eq("stats_hit", hit_cnt, 32'd4);
        check_eq("stats_miss", miss_cnt, 32'd1);
`endif

        // Conflict on index 0.
        fill(32'h0000_0000, 0);
        fill(32'h0000_0040, 1);
        fill(32'h0000_0000, 0);

        // Flush during a miss.
        step(1, 1, 1, 32'h0000_2000, 0, 0);
        step(1, 1, 1, 32'h0000_2000, 0, 0);
        step(1, 1, 1, 32'h0000_2000, 1, 0);
        step(1, 1, 1, 32'h0000_2000, 0, 1);
        fill(32'h0000_2000, 0);
        fill(32'h0000_1004, 0);

        // Stall with mem_done pulses while rdy is low.
        step(1, 1, 1, 32'h0000_5000, 0, 0);
        step(1, 1, 1, 32'h0000_5000, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 32'h0000_5000, 0, bit'(i % 2 == 0));
        step(1, 1, 1, 32'h0000_5000, 0, 1);
        step(1, 1, 1, 32'h0000_5000, 0, 0);

        // PC moves to a cached line while the miss is outstanding.
        fill(32'h0000_3008, 0);
        step(1, 1, 1, 32'h0000_3000, 0, 0);
        step(1, 1, 1, 32'h0000_3008, 0, 0);
        step(1, 1, 1, 32'h0000_3008, 0, 1);
        step(1, 1, 1, 32'h0000_3008, 0, 0);
        step(1, 1, 1, 32'h0000_3000, 0, 0);

        // Randomized traffic with a responsive memory model.
        lat = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 300) != 0;
            rdy = ($urandom % 10) != 0;
            req = ($urandom % 5) != 0;
            clr = ($urandom % 30) == 0;
            pc  = 32'h0000_1000 + (($urandom % 4) << 6) + (($urandom % 16) << 2) + ($urandom % 4);
            if (m_miss) done = rdy ? (lat == 0) : bit'($urandom % 2);
            else done = 1'b0;
            was = m_miss;
            step(rst, rdy, req, pc, clr, done);
            if (!was && m_miss) lat = $urandom % 5;
            else if (m_miss && rdy && rst && lat > 0) lat--;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-line instruction cache between the instruction fetch unit and the memory controller's icache port. Fetch lookups are combinational. Hits return an instruction in the same cycle. On a miss the block raises a word request to the memory controller, waits for completion, fills the line and replays the lookup.

## Interface
Parameters:
- INDEX_BITS, 4, log2 of line count (16 lines); tag = pc[31:INDEX_BITS+2]

Ports:
- clk_in  in  1  clock, rising edge
- rst_in  in  1  synchronous reset, active-low
- rdy_in  in  1  global ready; low freezes all state
- if_req  in  1  fetch request valid
- if_pc  in  32  fetch address; bits [1:0] ignored
- clear_in  in  1  invalidate all lines (pipeline flush / fence.i)
- if_ready  out  1  if_inst valid for current if_pc
- if_inst  out  32  instruction word
- mem_req  out  1  word-read request to memory controller (its icache_in)
- mem_addr  out  32  word-aligned request address
- mem_done  in  1  one-cycle pulse: mem_data valid
- mem_data  in  32  returned word, little-endian assembled by controller
- hit_cnt  out  32  (ICACHE_STATS_EN only) hit counter
- miss_cnt  out  32  (ICACHE_STATS_EN only) miss counter

## Operation
- Storage: valid[2^INDEX_BITS], tag array, data array; index = if_pc[INDEX_BITS+1:2].
- FSM states: IDLE, MISS.
- IDLE:
  - hit = if_req & valid[idx] & tag match.
  - if_ready = hit (combinational); if_inst = data[idx].
  - if_req & !hit & !clear_in: latch {if_pc[31:2],2'b00} into mem_addr; set mem_req; go to MISS.
- MISS:
  - mem_req held high and mem_addr held stable until mem_done.
  - if_ready = 0.
  - On mem_done: write data, tag, and valid for the latched address, unless the `discard` flag is set; clear mem_req; go to IDLE.
- clear_in (any state): all valid bits cleared at the clock edge.
  - In MISS, clear_in also sets `discard`. The outstanding request still completes because the controller cannot abort it, but the returned word is not written.
  - `discard` is cleared on leaving MISS.
- if_pc may change during MISS. The fill still targets the latched address. The new pc is looked up on return to IDLE.
- clear_in and a fill edge in the same cycle: the fill is dropped and the line stays invalid.
- rdy_in low: no state, valid, counter or output-register change. mem_done is ignored while rdy_in is low (the controller is paused too).
- Reset (rst_in == 0 at the edge): state IDLE, all valid = 0, mem_req = 0, mem_addr = 0, discard = 0, counters = 0.
  - if_ready = 0 and if_inst = 0 while valid is clear.
  - Reset during MISS abandons the request.

## Timing
- Hit: zero-cycle; if_ready in the same cycle as if_req.
- Miss detected in cycle t: mem_req first high in cycle t+1.
- mem_done in cycle d: the line is written at the end of d; mem_req is low in d+1; IDLE in d+1; if_ready in d+1 (same pc, no clear).
- Miss penalty = (d - t) + 1 cycles.
- mem_req never drops before mem_done, and never re-asserts in the cycle after mem_done.
- Only one outstanding request at a time.

## Configuration
- ICACHE_STATS_EN defined:
  - hit_cnt increments on each IDLE cycle with if_ready = 1 and rdy_in high.
  - miss_cnt increments on each IDLE→MISS transition.
  - Both are 32-bit and saturate at 0xFFFF_FFFF.
  - clear_in does not reset them; only rst_in does.
- Not defined: counters and their ports are absent. Functional behaviour is otherwise identical.

## Test plan
- Cold miss:
  - Stimulus: reset, then if_req = 1, if_pc = 0x0000_1004; memory model returns mem_done 3 cycles after mem_req with 0x0000_0013.
  - Required response: mem_addr = 0x0000_1004; mem_req high exactly 3 cycles; if_ready with if_inst = 0x0000_0013 one cycle after mem_done. A second fetch of 0x1004 hits with no mem_req.
- Conflict:
  - Stimulus: fill 0x0000_0000, then fetch 0x0000_0040 (same index, INDEX_BITS = 4).
  - Required response: miss, refill; a later fetch of 0x0000_0000 misses again.
- Flush during miss:
  - Stimulus: miss on 0x2000; clear_in pulsed in the cycle before mem_done.
  - Required response: mem_req still held until mem_done; the next 0x2000 lookup misses; all prior lines are invalid.
- Stall:
  - Stimulus: rdy_in low for 5 cycles mid-MISS, with mem_done asserted during the stall, then re-asserted after.
  - Required response: no state change during the stall; fill only on the rdy-high mem_done.
- PC change mid-miss:
  - Stimulus: miss on 0x3000; if_pc switches to 0x3008 (a cached hit) before mem_done.
  - Required response: the 0x3000 line is filled; if_ready for 0x3008 in the cycle after mem_done.
- Stats (ICACHE_STATS_EN):
  - Stimulus: 1 cold miss plus 4 hit cycles.
  - Required response: miss_cnt = 1, hit_cnt = 4.
